nios_sys_nios2_qsys_0_oci_dct_unpacker: RTL and testbench

NIOS_SYS_NIOS2_QSYS_0_OCI_DCT_UNPACKER -- requirements
Module: nios_sys_nios2_qsys_0_oci_dct_unpacker

---
 rtl/nios_sys_oci_trace_pkg.sv | 16 +
 rtl/nios_sys_oci_trace_fifo.sv | 60 ++++++
 rtl/nios_sys_nios2_qsys_0_oci_dct_unpacker.sv | 127 ++++++++++++
 tb/tb_nios_sys_nios2_qsys_0_oci_dct_unpacker.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios_sys_oci_trace_pkg.sv
// Shared constants and FSM encoding for the OCI DCT trace unpacker.
package nios_sys_oci_trace_pkg;

  localparam int CODE_W_DEF = 2;
  localparam int SLOTS_DEF  = 15;
  localparam int CNT_W_DEF  = 4;
  localparam int DEPTH_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UNPACK = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_DONE   = 2'd3
  } unpack_state_e;

endpackage

// File: rtl/nios_sys_oci_trace_fifo.sv
// Show-ahead code FIFO with synchronous flush. A write is taken while full
// when a read happens on the same edge; a read while empty is ignored.
module nios_sys_oci_trace_fifo #(
  parameter int W     = 2,
  parameter int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int LVL_W = AW + 1
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             flush_i,
  input  logic             wr_i,
  input  logic [W-1:0]     wdata_i,
  input  logic             rd_i,
  output logic [W-1:0]     rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] level_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] cnt_q;
  logic             rd_ok, wr_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == LVL_W'(DEPTH));
  assign level_o = cnt_q;
  assign rd_ok   = rd_i && !empty_o;
  assign wr_ok   = wr_i && (!full_o || rd_ok);
  // Head is forced to zero when empty so stale storage never leaks out.
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage array: data only, no reset needed.
  always_ff @(posedge gclk) begin
    if (wr_ok && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers and occupancy; flush wins over any same-cycle traffic.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_ok) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   cnt_q <= cnt_q + LVL_W'(1);
        2'b01:   cnt_q <= cnt_q - LVL_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/nios_sys_nios2_qsys_0_oci_dct_unpacker.sv
// Accepts packed DCT trace buffers, unpacks them one code per cycle into a
// show-ahead FIFO, and handles the end-of-test drain / abort sequence.
module nios_sys_nios2_qsys_0_oci_dct_unpacker
  import nios_sys_oci_trace_pkg::*;
#(
  parameter int CODE_W = CODE_W_DEF,
  parameter int SLOTS  = SLOTS_DEF,
  parameter int CNT_W  = CNT_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [CODE_W*SLOTS-1:0] dct_buffer,
  input  logic [CNT_W-1:0]        dct_count,
  input  logic                    dct_valid,
  output logic                    dct_ready,
  output logic [CODE_W-1:0]       code_data,
  output logic                    code_valid,
  input  logic                    code_ready,
  input  logic                    test_ending,
  input  logic                    test_has_ended,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    bad_count,
  output logic                    test_done,
  output logic [15:0]             code_total
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  unpack_state_e           state_q;
  logic [CODE_W*SLOTS-1:0] shadow_q;
  logic [CNT_W-1:0]        rem_q;
  logic                    bad_q;
  logic [15:0]             total_q, total_d;

  logic                    over_cnt;
  logic [CNT_W-1:0]        k_cnt;
  logic                    accept;
  logic                    fifo_full, fifo_empty;
  logic                    wr_en;
  logic [LVL_W-1:0]        fifo_level;

  // Counts beyond the buffer capacity are clamped and flagged.
  assign over_cnt  = (dct_count > CNT_W'(SLOTS));
  assign k_cnt     = over_cnt ? CNT_W'(SLOTS) : dct_count;
  assign dct_ready = (state_q == ST_IDLE) && !test_ending;
  assign accept    = dct_valid && dct_ready && !test_has_ended;

  // Write the current slot when there is room, including full-with-pop.
  // Abort suppresses the write so the flush leaves the FIFO truly empty.
  assign wr_en = (state_q == ST_UNPACK) && !test_has_ended &&
                 (!fifo_full || (code_ready && !fifo_empty));

  assign code_valid = !fifo_empty;
  assign level      = fifo_level;
  assign bad_count  = bad_q;
  assign test_done  = (state_q == ST_DONE);
  assign code_total = total_q;

  nios_sys_oci_trace_fifo #(
    .W     (CODE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .gclk    (clk),
    .grst_n  (reset_n),
    .flush_i (test_has_ended),
    .wr_i    (wr_en),
    .wdata_i (shadow_q[CODE_W-1:0]),
    .rd_i    (code_ready),
    .rdata_o (code_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  // Control FSM: slot 0 always sits at the bottom of the shadow, which is
  // shifted down one code per write so the FIFO data path needs no mux.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      rem_q    <= '0;
      bad_q    <= 1'b0;
    end else if (test_has_ended) begin
      state_q <= ST_DONE;
      rem_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (test_ending) begin
            state_q <= ST_DRAIN;
          end else if (accept) begin
            shadow_q <= dct_buffer;
            rem_q    <= k_cnt;
            if (over_cnt) bad_q <= 1'b1;
            if (k_cnt != '0) state_q <= ST_UNPACK;
          end
        end
        ST_UNPACK: begin
          if (wr_en) begin
            shadow_q <= shadow_q >> CODE_W;
            rem_q    <= rem_q - CNT_W'(1);
            if (rem_q == CNT_W'(1))
              state_q <= test_ending ? ST_DRAIN : ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (fifo_level == '0) state_q <= ST_DONE;
        end
        default: state_q <= ST_DONE;
      endcase
    end
  end

  // Saturating count of every code pushed into the FIFO.
  always_comb begin
    total_d = total_q;
    if (wr_en && (total_q != 16'hFFFF)) total_d = total_q + 16'd1;
  end

  // Register for the written-code total.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) total_q <= '0;
    else          total_q <= total_d;
  end

endmodule

// File: tb/tb_nios_sys_nios2_qsys_0_oci_dct_unpacker.sv
// Directed + randomized bench with a queue reference model of code ordering.
module tb_nios_sys_nios2_qsys_0_oci_dct_unpacker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        dct_valid, dct_ready;
  logic [1:0]  code_data;
  logic        code_valid, code_ready;
  logic        test_ending, test_has_ended;
  logic [4:0]  level;
  logic        bad_count, test_done;
  logic [15:0] code_total;

  // Second instance with a narrower buffer for the count-clamp case.
  logic [23:0] buf12;
  logic [3:0]  cnt12;
  logic        valid12, ready12, cv12, cr12, tend12, thend12;
  logic [1:0]  data12;
  logic [4:0]  level12;
  logic        bad12, done12;
  logic [15:0] total12;

  int n_assert = 0;
  int n_fail   = 0;
  int model_total = 0;
  logic [1:0] exp_q[$];
  logic       rand_ready = 1'b0;

  always #5 clk = ~clk;

  nios_sys_nios2_qsys_0_oci_dct_unpacker u_dut (
    .clk(clk), .reset_n(reset_n), .dct_buffer(dct_buffer), .dct_count(dct_count),
    .dct_valid(dct_valid), .dct_ready(dct_ready), .code_data(code_data),
    .code_valid(code_valid), .code_ready(code_ready), .test_ending(test_ending),
    .test_has_ended(test_has_ended), .level(level), .bad_count(bad_count),
    .test_done(test_done), .code_total(code_total)
  );

  nios_sys_nios2_qsys_0_oci_dct_unpacker #(.SLOTS(12)) u_dut12 (
    .clk(clk), .reset_n(reset_n), .dct_buffer(buf12), .dct_count(cnt12),
    .dct_valid(valid12), .dct_ready(ready12), .code_data(data12),
    .code_valid(cv12), .code_ready(cr12), .test_ending(tend12),
    .test_has_ended(thend12), .level(level12), .bad_count(bad12),
    .test_done(done12), .code_total(total12)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Update the model with what the coming edge will do, then advance.
  task automatic tick();
    if (dct_valid && dct_ready) begin
      int k;
      k = (int'(dct_count) > 15) ? 15 : int'(dct_count);
      for (int i = 0; i < k; i++) exp_q.push_back(dct_buffer[i*2 +: 2]);
      model_total += k;
    end
    if (code_valid && code_ready) begin
      if (exp_q.size() == 0) chk("unexpected_pop", 32'd1, 32'd0);
      else                   chk("code_order", {30'd0, code_data}, {30'd0, exp_q.pop_front()});
    end
    if (test_has_ended) exp_q.delete();
    @(posedge clk); #1;
    if (rand_ready) code_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!dct_ready && n < 300) begin tick(); n++; end
    chk(tag, {31'd0, dct_ready}, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    code_ready = 1'b1;
    while ((level != 0 || !dct_ready) && n < 300) begin tick(); n++; end
    chk(tag, {27'd0, level}, 32'd0);
  endtask

  task automatic offer(input logic [29:0] b, input logic [3:0] c);
    dct_buffer = b; dct_count = c; dct_valid = 1'b1;
    tick();
    dct_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_level"}, {27'd0, level}, 32'd0);
    chk({tag, "_cvalid"}, {31'd0, code_valid}, 32'd0);
    chk({tag, "_cdata"}, {30'd0, code_data}, 32'd0);
    chk({tag, "_bad"}, {31'd0, bad_count}, 32'd0);
    chk({tag, "_done"}, {31'd0, test_done}, 32'd0);
    chk({tag, "_total"}, {16'd0, code_total}, 32'd0);
  endtask

  initial begin
    reset_n = 1'b0; dct_buffer = '0; dct_count = '0; dct_valid = 1'b0;
    code_ready = 1'b0; test_ending = 1'b0; test_has_ended = 1'b0;
    buf12 = '0; cnt12 = '0; valid12 = 1'b0; cr12 = 1'b0; tend12 = 1'b0; thend12 = 1'b0;

    // Reset values
    #12;
    chk_reset_vals("rst0");
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    chk("ready_after_reset", {31'd0, dct_ready}, 32'd1);

    // Buffer 0x1B, 3 codes: 3,2,1 back to back, ready again after 4 cycles
    code_ready = 1'b1;
    offer(30'h0000_001B, 4'd3);
    chk("acc_ready_low", {31'd0, dct_ready}, 32'd0);
    tick();
    chk("c0_valid", {31'd0, code_valid}, 32'd1);
    chk("c0_data", {30'd0, code_data}, 32'd3);
    chk("c0_ready", {31'd0, dct_ready}, 32'd0);
    tick();
    chk("c1_data", {30'd0, code_data}, 32'd2);
    chk("c1_ready", {31'd0, dct_ready}, 32'd0);
    tick();
    chk("c2_data", {30'd0, code_data}, 32'd1);
    chk("c2_ready", {31'd0, dct_ready}, 32'd1);
    tick();
    chk("c3_empty", {31'd0, code_valid}, 32'd0);

    // Zero-count buffer: nothing written, stays ready
    offer(30'($urandom()), 4'd0);
    chk("zero_ready", {31'd0, dct_ready}, 32'd1);
    chk("zero_level", {27'd0, level}, 32'd0);

    // Backpressure: two 15-code buffers, FIFO caps at 16, no loss afterwards
    code_ready = 1'b0;
    offer(30'($urandom()), 4'd15);
    wait_ready("full_a_ready");
    offer(30'($urandom()), 4'd15);
    repeat (20) tick();
    chk("full_level", {27'd0, level}, 32'd16);
    chk("full_valid", {31'd0, code_valid}, 32'd1);
    chk("full_stall_ready", {31'd0, dct_ready}, 32'd0);
    drain("full_drain");
    chk("full_model_empty", exp_q.size(), 32'd0);
    chk("full_total", {16'd0, code_total}, model_total);
    chk("full_total33", {16'd0, code_total}, 32'd33);

    // Max count on the 15-slot instance: no clamp
    offer(30'($urandom()), 4'hF);
    drain("max15_drain");
    chk("max15_bad", {31'd0, bad_count}, 32'd0);
    chk("max15_total", {16'd0, code_total}, model_total);

    // Same count on a 12-slot instance: clamped to 12, flagged
    buf12 = 24'($urandom()); cnt12 = 4'hF; valid12 = 1'b1;
    tick();
    valid12 = 1'b0;
    repeat (14) tick();
    chk("s12_level", {27'd0, level12}, 32'd12);
    chk("s12_total", {16'd0, total12}, 32'd12);
    chk("s12_bad", {31'd0, bad12}, 32'd1);
    chk("s12_head", {30'd0, data12}, {30'd0, buf12[1:0]});

    // Randomized buffers with random consumer backpressure
    rand_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      wait_ready("rnd_ready");
      offer(30'($urandom()), 4'($urandom_range(0, 15)));
    end
    rand_ready = 1'b0;
    drain("rnd_drain");
    chk("rnd_model_empty", exp_q.size(), 32'd0);
    chk("rnd_total", {16'd0, code_total}, model_total);

    // test_ending mid-unpack with 5 slots left: all delivered, drain, done
    code_ready = 1'b1;
    offer(30'($urandom()), 4'd10);
    repeat (5) tick();
    test_ending = 1'b1;
    chk("end_ready_low", {31'd0, dct_ready}, 32'd0);
    begin
      int n = 0;
      while (!test_done && n < 100) begin tick(); n++; end
    end
    chk("end_done", {31'd0, test_done}, 32'd1);
    chk("end_level", {27'd0, level}, 32'd0);
    chk("end_model_empty", exp_q.size(), 32'd0);
    chk("end_total", {16'd0, code_total}, model_total);
    test_ending = 1'b0;
    tick();
    chk("done_sticky", {31'd0, test_done}, 32'd1);
    chk("done_ready", {31'd0, dct_ready}, 32'd0);
    chk("done_cvalid", {31'd0, code_valid}, 32'd0);

    // Reset, then abort with 9 codes queued mid-unpack
    reset_n = 1'b0;
    #2;
    chk_reset_vals("rst1");
    exp_q.delete(); model_total = 0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
    chk("ready_after_reset2", {31'd0, dct_ready}, 32'd1);
    code_ready = 1'b0;
    offer(30'($urandom()), 4'd15);
    repeat (9) tick();
    chk("abort_pre_level", {27'd0, level}, 32'd9);
    test_has_ended = 1'b1;
    tick();
    chk("abort_level", {27'd0, level}, 32'd0);
    chk("abort_done", {31'd0, test_done}, 32'd1);
    chk("abort_cvalid", {31'd0, code_valid}, 32'd0);
    chk("abort_ready", {31'd0, dct_ready}, 32'd0);
    test_has_ended = 1'b0;
    tick(); tick();
    chk("abort_abandon", {27'd0, level}, 32'd0);
    chk("abort_total", {16'd0, code_total}, 32'd9);

    // Asynchronous reset mid-cycle returns everything to reset values
    reset_n = 1'b0;
    #2;
    chk_reset_vals("rst2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
